hazard_detection_unit: RTL and testbench
========================================

Name: hazard_detection_unit

Overview:
Load-use hazard detector for the 5-stage RISC-V pipeline, sitting beside the ID stage.
- It records the destination register and load flag of the instruction most recently issued into ID/EX.
- It compares that record against the source registers of the instruction presented for issue.
- On a load-use dependency it stalls PC and IF/ID for exactly one cycle and injects a bubble into ID/EX.

Parameters:
REG_ADDR_W, 5, register-index width (32 architectural registers).
CNT_W, 16, width of the saturating stall-event counter.

Ports:
clk  input  1  pipeline clock, rising-edge active.
rst_n  input  1  asynchronous active-low reset.
IDEX_valid  input  1  an instruction is presented for issue into ID/EX this cycle.
IDEX_rs1  input  REG_ADDR_W  source register 1 of the presented instruction.
IDEX_rs2  input  REG_ADDR_W  source register 2 of the presented instruction.
IDEX_use_rs1  input  1  presented instruction actually reads rs1.
IDEX_use_rs2  input  1  presented instruction actually reads rs2.
IDEX_rd  input  REG_ADDR_W  destination register of the presented instruction.
IDEX_MemRead  input  1  presented instruction is a load.
flush  input  1  branch/jump flush; the presented instruction is squashed.
stall  output  1  load-use hazard; combinational.
pc_write  output  1  PC update enable; equals ~stall.
ifid_write  output  1  IF/ID register write enable; equals ~stall.
bubble  output  1  zero ID/EX control signals this cycle; equals stall | flush.
stall_count  output  CNT_W  number of stall cycles since reset, saturating.

Behaviour:
Internal state:
- prev_rd (REG_ADDR_W bits) and prev_load (1 bit) describe the instruction currently in EX.
- Both are cleared asynchronously while rst_n=0.

Stall condition (combinational, same cycle):
- stall = prev_load & (prev_rd != 0) & IDEX_valid & ~flush & ((IDEX_use_rs1 & IDEX_rs1==prev_rd) | (IDEX_use_rs2 & IDEX_rs2==prev_rd)).

Register update at rising clk edge:
- If stall or flush or ~IDEX_valid: prev_load<=0 and prev_rd<=0, i.e. a bubble enters EX.
- Otherwise: prev_rd<=IDEX_rd and prev_load<=IDEX_MemRead, i.e. the instruction issues.

Stall length:
- A stall lasts exactly one cycle: the bubble clears prev_load, so the held instruction issues on the next cycle.
- Two back-to-back loads, where the second depends on the first, give one stall. The second load then becomes prev and may stall its own consumer.

Register x0:
- Writes to x0 never cause a stall, even when rs1 or rs2 is 0.

Self-dependence:
- The presented instruction's own rd never affects its own stall. Only the previously issued instruction matters, so `lw x2,0(x2)` alone does not stall.

Flush:
- Flush has priority over stall: stall=0 and bubble=1.

stall_count:
- Increments by 1 at every rising edge where stall=1.
- Holds at all-ones on saturation.
- Reset value is 0.

Outputs under reset:
- While rst_n=0, stall=0, pc_write=1, ifid_write=1, stall_count=0.
- bubble = flush during reset.

Reset mid-stall:
- Asserting rst_n=0 during a stall drops stall immediately, because prev_load is cleared asynchronously.

Latency:
- stall/pc_write/ifid_write/bubble: zero-cycle, combinational from inputs and state.
- State and counter update: one cycle.

Test Plan:
- Reset, then cycle 1: valid=1, rs1=2, rs2=0, rd=2, MemRead=1 (`lw x2,0(x2)`) -> stall=0. Cycle 2: rs1=3, rs2=2, rd=4, MemRead=0, use_rs1=use_rs2=1 (`add x4,x3,x2`) -> stall=1, pc_write=0, bubble=1. Cycle 3, same inputs -> stall=0, stall_count=1.
- Previous `add` (MemRead=0, rd=4), then rs1=4, rs2=2 -> stall=0 (no load, no stall).
- Previous load with rd=4, then rs1=1, rs2=2 -> stall=0. Previous load with rd=0, then rs1=0 -> stall=0.
- Previous load with rd=5, then rs2=5, use_rs2=0 -> stall=0. Same with use_rs2=1 -> stall=1. Same with use_rs2=1 and flush=1 -> stall=0, bubble=1, and the next cycle has no stall.
- Load rd=7 issued, dependent rs1=7 presented; assert rst_n=0 mid-cycle -> stall falls to 0 asynchronously and stall_count=0.
- Drive 70000 consecutive hazard pairs -> stall_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector beside ID: tracks the instruction in EX and stalls PC/IF-ID for one
// cycle when the instruction presented for issue reads a register a preceding load writes.
module hazard_detection_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  IDEX_valid,
    input  logic [REG_ADDR_W-1:0] IDEX_rs1,
    input  logic [REG_ADDR_W-1:0] IDEX_rs2,
    input  logic                  IDEX_use_rs1,
    input  logic                  IDEX_use_rs2,
    input  logic [REG_ADDR_W-1:0] IDEX_rd,
    input  logic                  IDEX_MemRead,
    input  logic                  flush,
    output logic                  stall,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  bubble,
    output logic [CNT_W-1:0]      stall_count
);

    logic [REG_ADDR_W-1:0] prev_rd;
    logic                  prev_load;
    logic                  rs1_match;
    logic                  rs2_match;
    logic                  issue;

    always_comb begin
        rs1_match  = IDEX_use_rs1 && (IDEX_rs1 == prev_rd);
        rs2_match  = IDEX_use_rs2 && (IDEX_rs2 == prev_rd);
        // x0 is never a real producer, so a load targeting it cannot create a dependency
        stall      = prev_load && (prev_rd != '0) && IDEX_valid && !flush
                     && (rs1_match || rs2_match);
        pc_write   = !stall;
        ifid_write = !stall;
        bubble     = stall || flush;
        issue      = IDEX_valid && !flush && !stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_rd   <= '0;
            prev_load <= 1'b0;
        end else if (issue) begin
            prev_rd   <= IDEX_rd;
            prev_load <= IDEX_MemRead;
        end else begin
            prev_rd   <= '0;
            prev_load <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed and randomised checks of hazard_detection_unit against a behavioural pipeline model;
// a second narrow-counter instance exercises counter saturation within a short run.
module tb_hazard_detection_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       IDEX_valid = 1'b0;
    logic [4:0] IDEX_rs1 = '0;
    logic [4:0] IDEX_rs2 = '0;
    logic       IDEX_use_rs1 = 1'b0;
    logic       IDEX_use_rs2 = 1'b0;
    logic [4:0] IDEX_rd = '0;
    logic       IDEX_MemRead = 1'b0;
    logic       flush = 1'b0;

    logic        stall, pc_write, ifid_write, bubble;
    logic [15:0] stall_count;
    logic        s_stall, s_pc_write, s_ifid_write, s_bubble;
    logic [3:0]  s_stall_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hazard_detection_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .IDEX_valid(IDEX_valid), .IDEX_rs1(IDEX_rs1),
        .IDEX_rs2(IDEX_rs2), .IDEX_use_rs1(IDEX_use_rs1), .IDEX_use_rs2(IDEX_use_rs2),
        .IDEX_rd(IDEX_rd), .IDEX_MemRead(IDEX_MemRead), .flush(flush), .stall(stall),
        .pc_write(pc_write), .ifid_write(ifid_write), .bubble(bubble),
        .stall_count(stall_count)
    );

    hazard_detection_unit #(.REG_ADDR_W(5), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .IDEX_valid(IDEX_valid), .IDEX_rs1(IDEX_rs1),
        .IDEX_rs2(IDEX_rs2), .IDEX_use_rs1(IDEX_use_rs1), .IDEX_use_rs2(IDEX_use_rs2),
        .IDEX_rd(IDEX_rd), .IDEX_MemRead(IDEX_MemRead), .flush(flush), .stall(s_stall),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .bubble(s_bubble),
        .stall_count(s_stall_count)
    );

    // Model: what sits in EX is either nothing, or a real instruction with its rd/load flag
    bit       ex_occupied;
    int       ex_rd;
    bit       ex_is_load;
    int       m_stalls;

    function automatic bit reads_reg(int r);
        return (IDEX_use_rs1 && int'(IDEX_rs1) == r) || (IDEX_use_rs2 && int'(IDEX_rs2) == r);
    endfunction

    function automatic bit model_hazard();
        if (!IDEX_valid || flush || !ex_occupied || !ex_is_load || ex_rd == 0) return 1'b0;
        return reads_reg(ex_rd);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_occupied <= 1'b0;
            ex_rd       <= 0;
            ex_is_load  <= 1'b0;
            m_stalls    <= 0;
        end else begin
            if (model_hazard()) m_stalls <= m_stalls + 1;
            ex_occupied <= IDEX_valid && !flush && !model_hazard();
            ex_rd       <= int'(IDEX_rd);
            ex_is_load  <= IDEX_MemRead;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit hz;
        hz = model_hazard();
        check("stall", 32'(stall), 32'(hz));
        check("pc_write", 32'(pc_write), 32'(!hz));
        check("ifid_write", 32'(ifid_write), 32'(!hz));
        check("bubble", 32'(bubble), 32'(hz || flush));
        check("stall_count", 32'(stall_count), 32'((m_stalls > 65535) ? 65535 : m_stalls));
        check("stall_count_small", 32'(s_stall_count), 32'((m_stalls > 15) ? 15 : m_stalls));
    end

    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic mr, input logic fl);
        @(posedge clk);
        #1;
        IDEX_valid   = v;
        IDEX_rs1     = r1;
        IDEX_rs2     = r2;
        IDEX_use_rs1 = u1;
        IDEX_use_rs2 = u2;
        IDEX_rd      = rd;
        IDEX_MemRead = mr;
        flush        = fl;
        #1;
    endtask

    initial begin
        flush = 1'b1;
        #12;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_pc_write", 32'(pc_write), 32'd1);
        check("reset_bubble_is_flush", 32'(bubble), 32'd1);
        check("reset_count", 32'(stall_count), 32'd0);
        flush = 1'b0;
        #10;
        @(posedge clk);
        #1 rst_n = 1'b1;

        drive(1, 5'd2, 5'd0, 1, 0, 5'd2, 1, 0);            // lw x2,0(x2)
        check("self_dep_no_stall", 32'(stall), 32'd0);
        drive(1, 5'd3, 5'd2, 1, 1, 5'd4, 0, 0);            // add x4,x3,x2
        check("loaduse_stall", 32'(stall), 32'd1);
        check("loaduse_pc_write", 32'(pc_write), 32'd0);
        check("loaduse_bubble", 32'(bubble), 32'd1);
        drive(1, 5'd3, 5'd2, 1, 1, 5'd4, 0, 0);
        check("one_cycle_stall", 32'(stall), 32'd0);
        check("count_after_one", 32'(stall_count), 32'd1);
        drive(1, 5'd4, 5'd2, 1, 1, 5'd4, 1, 0);
        check("prev_not_load", 32'(stall), 32'd0);
        drive(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0);
        check("no_reg_match", 32'(stall), 32'd0);
        drive(1, 5'd0, 5'd0, 1, 1, 5'd6, 0, 0);
        check("x0_no_stall", 32'(stall), 32'd0);
        drive(1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 0);
        drive(1, 5'd1, 5'd5, 1, 0, 5'd6, 0, 0);
        check("rs2_unused", 32'(stall), 32'd0);
        drive(1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 0);
        drive(1, 5'd1, 5'd5, 1, 1, 5'd6, 0, 0);
        check("rs2_used", 32'(stall), 32'd1);
        drive(1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 0);
        drive(1, 5'd1, 5'd5, 1, 1, 5'd6, 0, 1);
        check("flush_no_stall", 32'(stall), 32'd0);
        check("flush_bubble", 32'(bubble), 32'd1);
        drive(1, 5'd1, 5'd5, 1, 1, 5'd6, 0, 0);
        check("after_flush", 32'(stall), 32'd0);
        check("count_before_reset", 32'(stall_count), 32'd2);

        // Reset mid-stall
        drive(1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 0);
        drive(1, 5'd7, 5'd0, 1, 0, 5'd8, 0, 0);
        check("pre_reset_stall", 32'(stall), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_stall", 32'(stall), 32'd0);
        check("async_reset_count", 32'(stall_count), 32'd0);
        check("async_reset_ifid", 32'(ifid_write), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Dependent back-to-back loads: one stall each, second load then stalls its consumer
        drive(1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0);
        drive(1, 5'd3, 5'd0, 1, 0, 5'd4, 1, 0);
        check("load_load_stall", 32'(stall), 32'd1);
        drive(1, 5'd3, 5'd0, 1, 0, 5'd4, 1, 0);
        check("load_load_issue", 32'(stall), 32'd0);
        drive(1, 5'd4, 5'd9, 1, 1, 5'd10, 0, 0);
        check("load_chain_stall", 32'(stall), 32'd1);
        drive(0, 5'd4, 5'd9, 1, 1, 5'd10, 0, 0);

        // Hazard pairs well past the narrow counter's limit
        for (int i = 0; i < 20; i++) begin
            drive(1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0);
            drive(1, 5'd3, 5'd1, 1, 1, 5'd8, 0, 0);
        end
        drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
        check("small_saturated", 32'(s_stall_count), 32'd15);
        check("wide_count", 32'(stall_count), 32'd22);

        for (int i = 0; i < 400; i++) begin
            drive(logic'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 7) == 0));
        end
        drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
        @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
